// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-back path.
// Register map and width defaults used by rf_wb_arbiter and issue logic.
package rf_pkg;
  localparam int RF_AW    = 4;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 16;
  localparam int REG_PC   = 15;
  localparam int REG_LR   = 14;
  localparam int REG_SP   = 13;
  localparam int RF_NREQ  = 3;
endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: search starts after last_grant.
// Ports: req[N] in, last_grant in; grant (one-hot), idx, any out.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last_grant) + k) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back controller: round-robin share of the RF write port,
// one-cycle commit register, and a busy scoreboard for issue.
// Ports: clk, Reset; req_valid/rw/data -> req_ready;
// issue_valid/rd -> issue_ready; flush; rf_regwrite/rw/rfin; busy.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rw,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  output logic                 issue_ready,
  input  logic                 flush,
  output logic                 rf_regwrite,
  output logic [AW-1:0]        rf_rw,
  output logic [DW-1:0]        rf_rfin,
  output logic [RF_NREGS-1:0]  busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]     grant;
  logic [LW-1:0]       gidx;
  logic [LW-1:0]       last_grant;
  logic                any;
  logic [AW-1:0]       win_rw;
  logic [DW-1:0]       win_data;
  logic [RF_NREGS-1:0] busy_nxt;

  rr_arbiter #(
    .N  (NREQ),
    .IW (LW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .idx        (gidx),
    .any        (any)
  );

  assign req_ready = grant;
  assign win_rw    = req_rw[int'(gidx)*AW +: AW];
  assign win_data  = req_data[int'(gidx)*DW +: DW];

  // A register being written this cycle may be re-reserved at once.
  assign issue_ready = !busy[issue_rd] ||
                       (rf_regwrite && rf_rw == issue_rd);

  // Order matters: clear, then set (set wins), then flush (wins all).
  always_comb begin
    busy_nxt = busy;
    if (rf_regwrite)
      busy_nxt[rf_rw] = 1'b0;
    if (issue_valid && issue_ready)
      busy_nxt[issue_rd] = 1'b1;
    if (flush)
      busy_nxt = '0;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      last_grant  <= LW'(NREQ - 1);
      rf_regwrite <= 1'b0;
      rf_rw       <= '0;
      rf_rfin     <= '0;
      busy        <= '0;
    end else begin
      busy        <= busy_nxt;
      rf_regwrite <= any;
      if (any) begin
        last_grant <= gidx;
        rf_rw      <= win_rw;
        rf_rfin    <= win_data;
      end
    end
  end

endmodule
